// File: rtl/reg_writeback_pkg.sv
// Shared defaults and types for the register writeback block.
package reg_wb_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int WIDTH_DEF      = 32;
  localparam int DEPTH_DEF      = 16;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] rd;
    logic [WIDTH_DEF-1:0]      data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LOAD = 2'd2
  } wb_src_e;

endpackage

// File: rtl/reg_writeback_if.sv
// Result, issue and register-file write signals of the writeback stage.
interface reg_writeback_if
  import reg_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
);

  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [WIDTH-1:0]      alu_data;

  logic                  ld_valid;
  logic                  ld_ready;
  logic [ADDR_WIDTH-1:0] ld_rd;
  logic [WIDTH-1:0]      ld_data;

  logic                  issue_en;
  logic [ADDR_WIDTH-1:0] issue_rd;

  logic [DEPTH-1:0]      busy;
  logic                  reg_write_en;
  logic [ADDR_WIDTH-1:0] destination_reg;
  logic [WIDTH-1:0]      write_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output issue_en, issue_rd,
    input  alu_ready, ld_ready,
    input  busy, reg_write_en, destination_reg, write_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  issue_en, issue_rd,
    output alu_ready, ld_ready,
    output busy, reg_write_en, destination_reg, write_data
  );

endinterface

// File: rtl/reg_writeback_fifo2.sv
// Two-entry FIFO holding load results until they win the write port.
module wb_fifo2
  import reg_wb_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push_ok, pop_ok;

  always_comb begin
    push_ok  = push && (count_q != 2'd2);
    pop_ok   = pop && (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/reg_writeback.sv
// Writeback arbiter: ALU results win the register-file port, loads queue in a
// 2-entry FIFO; also keeps the per-register pending-write scoreboard.
module reg_writeback
  import reg_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input logic            clk,
  input logic            rst,
  reg_writeback_if.slave bus
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [WIDTH-1:0]      data;
  } entry_t;

  entry_t           alu_entry, ld_entry, head, sel;
  wb_src_e          src;
  logic [1:0]       fifo_count;
  logic             alu_fire, ld_fire, pop;

  logic             reg_write_en_q, reg_write_en_d;
  logic [ADDR_WIDTH-1:0] destination_reg_q, destination_reg_d;
  logic [WIDTH-1:0] write_data_q, write_data_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] set_mask, clr_mask;

  function automatic logic rd_ok(input logic [ADDR_WIDTH-1:0] rd);
    return (rd != '0) && (32'(rd) < DEPTH);
  endfunction

  // A full FIFO blocks the ALU so the head is guaranteed to drain.
  assign bus.ld_ready  = (fifo_count < 2'd2);
  assign bus.alu_ready = (fifo_count != 2'd2);
  assign alu_fire      = bus.alu_valid && bus.alu_ready;
  assign ld_fire       = bus.ld_valid && bus.ld_ready;
  assign alu_entry     = '{rd: bus.alu_rd, data: bus.alu_data};
  assign ld_entry      = '{rd: bus.ld_rd, data: bus.ld_data};

  always_comb begin
    src = SRC_NONE;
    if (alu_fire) begin
      src = SRC_ALU;
    end else if (fifo_count != 2'd0) begin
      src = SRC_LOAD;
    end
  end

  assign pop = (src == SRC_LOAD);

  wb_fifo2 #(
    .entry_t(entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (ld_fire),
    .push_data(ld_entry),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count)
  );

  always_comb begin
    sel = '0;
    case (src)
      SRC_ALU:  sel = alu_entry;
      SRC_LOAD: sel = head;
      default:  sel = '0;
    endcase
    reg_write_en_d    = (src != SRC_NONE) && rd_ok(sel.rd);
    destination_reg_d = reg_write_en_d ? sel.rd : destination_reg_q;
    write_data_d      = reg_write_en_d ? sel.data : write_data_q;
  end

  // Clear from the retiring write is applied before the new issue, so set wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.issue_en && rd_ok(bus.issue_rd)) begin
      set_mask = DEPTH'(1) << bus.issue_rd;
    end
    if (reg_write_en_q) begin
      clr_mask = DEPTH'(1) << destination_reg_q;
    end
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_en_q    <= 1'b0;
      destination_reg_q <= '0;
      write_data_q      <= '0;
      busy_q            <= '0;
    end else begin
      reg_write_en_q    <= reg_write_en_d;
      destination_reg_q <= destination_reg_d;
      write_data_q      <= write_data_d;
      busy_q            <= busy_d;
    end
  end

  assign bus.reg_write_en    = reg_write_en_q;
  assign bus.destination_reg = destination_reg_q;
  assign bus.write_data      = write_data_q;
  assign bus.busy            = busy_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback.
module tb_reg_writeback;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  reg_writeback_if #(.ADDR_WIDTH(5), .WIDTH(32), .DEPTH(16)) bus ();

  reg_writeback #(.ADDR_WIDTH(5), .WIDTH(32), .DEPTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
    bus.issue_en  = 1'b0; bus.issue_rd = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    tick(); tick();
    check("rst_wen",   64'(bus.reg_write_en), 64'd0);
    check("rst_dest",  64'(bus.destination_reg), 64'd0);
    check("rst_data",  64'(bus.write_data), 64'd0);
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_aluR",  64'(bus.alu_ready), 64'd1);
    check("rst_ldR",   64'(bus.ld_ready), 64'd1);
    rst = 1'b0;
    tick();

    // single ALU write
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1 check("alu_ready", 64'(bus.alu_ready), 64'd1);
    tick();
    bus.alu_valid = 1'b0;
    check("alu_wen",  64'(bus.reg_write_en), 64'd1);
    check("alu_dest", 64'(bus.destination_reg), 64'd5);
    check("alu_data", 64'(bus.write_data), 64'hDEADBEEF);
    tick();
    check("idle_wen",  64'(bus.reg_write_en), 64'd0);
    check("hold_dest", 64'(bus.destination_reg), 64'd5);
    check("hold_data", 64'(bus.write_data), 64'hDEADBEEF);

    // rd = 0 is consumed without a write
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1;
    tick();
    bus.alu_valid = 1'b0;
    check("rd0_wen",   64'(bus.reg_write_en), 64'd0);
    check("rd0_aluR",  64'(bus.alu_ready), 64'd1);
    check("rd0_busy",  64'(bus.busy), 64'd0);
    check("rd0_dest",  64'(bus.destination_reg), 64'd5);

    // ALU and loads every cycle
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'hA0A0A0A0;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd1; bus.ld_data = 32'h11111111;
    tick();
    check("mix1_dest", 64'(bus.destination_reg), 64'd10);
    check("mix1_ldR",  64'(bus.ld_ready), 64'd1);
    bus.ld_rd = 5'd2; bus.ld_data = 32'h22222222;
    tick();
    check("mix2_dest", 64'(bus.destination_reg), 64'd10);
    check("mix2_aluR", 64'(bus.alu_ready), 64'd0);
    check("mix2_ldR",  64'(bus.ld_ready), 64'd0);
    bus.ld_rd = 5'd3; bus.ld_data = 32'h33333333;
    tick();
    check("mix3_wen",  64'(bus.reg_write_en), 64'd1);
    check("mix3_dest", 64'(bus.destination_reg), 64'd1);
    check("mix3_data", 64'(bus.write_data), 64'h11111111);
    check("mix3_aluR", 64'(bus.alu_ready), 64'd1);
    tick();
    bus.ld_valid = 1'b0;
    check("mix4_dest", 64'(bus.destination_reg), 64'd10);
    check("mix4_aluR", 64'(bus.alu_ready), 64'd0);
    tick();
    bus.alu_valid = 1'b0;
    check("mix5_dest", 64'(bus.destination_reg), 64'd2);
    check("mix5_data", 64'(bus.write_data), 64'h22222222);
    tick();
    check("mix6_dest", 64'(bus.destination_reg), 64'd3);
    check("mix6_data", 64'(bus.write_data), 64'h33333333);
    tick();
    check("mix7_wen",  64'(bus.reg_write_en), 64'd0);
    check("mix7_busy", 64'(bus.busy), 64'd0);

    // scoreboard: issue, then load retires
    bus.issue_en = 1'b1; bus.issue_rd = 5'd7;
    tick();
    bus.issue_en = 1'b0;
    check("sb_set", 64'(bus.busy), 64'h0080);
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h77;
    tick();
    bus.ld_valid = 1'b0;
    check("nobypass_wen", 64'(bus.reg_write_en), 64'd0);
    check("sb_pending",   64'(bus.busy), 64'h0080);
    tick();
    check("ld7_wen",  64'(bus.reg_write_en), 64'd1);
    check("ld7_dest", 64'(bus.destination_reg), 64'd7);
    check("ld7_busy", 64'(bus.busy), 64'h0080);
    tick();
    check("sb_clr", 64'(bus.busy), 64'h0000);

    // issue in the same cycle as retire: set wins
    bus.issue_en = 1'b1; bus.issue_rd = 5'd7;
    tick();
    bus.issue_en = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h78;
    tick();
    bus.ld_valid = 1'b0;
    tick();
    check("race_wen", 64'(bus.reg_write_en), 64'd1);
    bus.issue_en = 1'b1; bus.issue_rd = 5'd7;
    tick();
    bus.issue_en = 1'b0;
    check("race_busy1", 64'(bus.busy), 64'h0080);
    tick();
    check("race_busy2", 64'(bus.busy), 64'h0080);

    // out-of-range indices
    bus.issue_en = 1'b1; bus.issue_rd = 5'd0;
    tick();
    bus.issue_rd = 5'd20;
    tick();
    bus.issue_en = 1'b0;
    check("oor_busy", 64'(bus.busy), 64'h0080);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'h5;
    tick();
    bus.alu_valid = 1'b0;
    check("oor_wen",  64'(bus.reg_write_en), 64'd0);
    check("oor_dest", 64'(bus.destination_reg), 64'd7);
    check("oor_data", 64'(bus.write_data), 64'h78);

    // reset with two loads buffered
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.ld_data = 32'h33;
    tick();
    bus.ld_rd = 5'd4; bus.ld_data = 32'h44;
    tick();
    bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;
    check("pre_rst_ldR", 64'(bus.ld_ready), 64'd0);
    check("pre_rst_wen", 64'(bus.reg_write_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wen",  64'(bus.reg_write_en), 64'd0);
    check("mid_rst_dest", 64'(bus.destination_reg), 64'd0);
    check("mid_rst_data", 64'(bus.write_data), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_aluR", 64'(bus.alu_ready), 64'd1);
    check("mid_rst_ldR",  64'(bus.ld_ready), 64'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_wen", 64'(bus.reg_write_en), 64'd0);
      check("post_rst_ldR", 64'(bus.ld_ready), 64'd1);
    end
    check("post_rst_dest", 64'(bus.destination_reg), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
